// File: rtl/pc_ctrl_pkg.sv
// Shared encodings for the PC trap controller.
// Holds the PC source select values driven to the PC unit, the trap cause
// codes reported on the cause output, and the controller state type.
package pc_ctrl_pkg;

  // PC source select values understood by the PC unit
  localparam logic [2:0] PCSRC_PLUS4  = 3'd0;
  localparam logic [2:0] PCSRC_BRANCH = 3'd1;
  localparam logic [2:0] PCSRC_JUMP   = 3'd2;
  localparam logic [2:0] PCSRC_JR     = 3'd3;
  localparam logic [2:0] PCSRC_ILLOP  = 3'd4;
  localparam logic [2:0] PCSRC_XADR   = 3'd5;
  localparam logic [2:0] PCSRC_HOLD   = 3'd7;

  // Reason for the most recently taken trap
  localparam logic [1:0] CAUSE_NONE  = 2'd0;
  localparam logic [1:0] CAUSE_ILLOP = 2'd1;
  localparam logic [1:0] CAUSE_IRQ   = 2'd2;

  // Controller states: normal execution or debug halt
  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } ctrl_state_t;

endpackage

// File: rtl/irq_sync.sv
// Interrupt request conditioning.
// Brings the asynchronous irq level into the clk domain, detects its rising
// edge and keeps a pending flag until software acknowledges it or the
// controller takes the interrupt.
// Ports:
//   clk, reset  - clock and asynchronous active-low reset
//   irq         - raw asynchronous interrupt level
//   irq_clr     - software acknowledge, drops the pending flag
//   take        - controller is taking the interrupt this cycle
//   irq_pend    - an interrupt edge has been seen and not yet serviced
module irq_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic irq,
  input  logic irq_clr,
  input  logic take,
  output logic irq_pend
);

  logic [SYNC_STAGES-1:0] sync;
  logic                   sync_prev;
  logic                   rise;

  assign rise = sync[SYNC_STAGES-1] && !sync_prev;

  // Synchroniser chain plus one extra flop that remembers the previous
  // synchronised level, so a held-high irq produces only one edge.
  // A new edge has precedence over a clear in the same cycle so that an
  // interrupt arriving as the previous one is serviced is not lost.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync      <= '0;
      sync_prev <= 1'b0;
      irq_pend  <= 1'b0;
    end else begin
      sync      <= {sync[SYNC_STAGES-2:0], irq};
      sync_prev <= sync[SYNC_STAGES-1];
      if (rise)
        irq_pend <= 1'b1;
      else if (irq_clr || take)
        irq_pend <= 1'b0;
    end
  end

endmodule

// File: rtl/pc_trap_ctrl.sv
// PC source sequencer with trap, interrupt and debug-halt arbitration.
// Every cycle it chooses the PC source: the decoder's choice, the illegal
// opcode vector, the interrupt vector, or a hold while halted. On a trap it
// kills the current instruction's writes and supplies the EPC value.
// Kernel mode is pc[31]=1; interrupts are only taken in user mode, and only
// after at least one user instruction has run since leaving kernel mode.
// Ports:
//   clk, reset        - clock and asynchronous active-low reset
//   dec_pcsrc         - decoder PC source for the current instruction
//   illop             - current instruction is undefined
//   irq, irq_clr      - asynchronous interrupt request and its acknowledge
//   halt_req          - debug halt request (level)
//   pc, plus4         - current PC and PC+4
//   pcsrc             - select to the PC unit
//   kill              - suppress writes of the current instruction
//   epc_we, epc_data  - EPC ($26) write strobe and value
//   cause             - last trap cause
//   dbl_fault         - sticky: illegal opcode taken in kernel mode
//   halted            - controller is in the halt state
//   trap_cnt          - saturating count of taken traps
module pc_trap_ctrl
  import pc_ctrl_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       dec_pcsrc,
  input  logic             illop,
  input  logic             irq,
  input  logic             irq_clr,
  input  logic             halt_req,
  input  logic [31:0]      pc,
  input  logic [31:0]      plus4,
  output logic [2:0]       pcsrc,
  output logic             kill,
  output logic             epc_we,
  output logic [31:0]      epc_data,
  output logic [1:0]       cause,
  output logic             dbl_fault,
  output logic             halted,
  output logic [CNT_W-1:0] trap_cnt
);

  ctrl_state_t state;
  logic        prev_k;
  logic        irq_pend;
  logic        ie;
  logic        take_illop;
  logic        take_irq;

  // prev_k holds the previous cycle's mode, so the first user cycle after
  // an eret is never interrupted and the handler's return makes progress.
  assign ie = !pc[31] && !prev_k;

  assign take_illop = (state == ST_RUN) && illop;
  assign take_irq   = (state == ST_RUN) && !illop && irq_pend && ie;

  irq_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk     (clk),
    .reset   (reset),
    .irq     (irq),
    .irq_clr (irq_clr),
    .take    (take_irq),
    .irq_pend(irq_pend)
  );

  // Same-cycle PC source selection. An illegal opcode in kernel mode must
  // not overwrite EPC, otherwise the original user return address is lost.
  // The interrupt saves the current pc so the preempted instruction reruns.
  always_comb begin
    pcsrc    = dec_pcsrc;
    kill     = 1'b0;
    epc_we   = 1'b0;
    epc_data = 32'h0000_0000;
    if (state == ST_HALT) begin
      pcsrc = PCSRC_HOLD;
      kill  = 1'b1;
    end else if (take_illop) begin
      pcsrc = PCSRC_ILLOP;
      kill  = 1'b1;
      if (!pc[31]) begin
        epc_we   = 1'b1;
        epc_data = plus4;
      end
    end else if (take_irq) begin
      pcsrc    = PCSRC_XADR;
      kill     = 1'b1;
      epc_we   = 1'b1;
      epc_data = pc;
    end
  end

  // Controller state and status. A halt request is only honoured in a cycle
  // with no trap so the trap's vector fetch is never frozen mid-redirect.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_RUN;
      halted    <= 1'b0;
      prev_k    <= 1'b1;
      cause     <= CAUSE_NONE;
      dbl_fault <= 1'b0;
      trap_cnt  <= '0;
    end else begin
      prev_k <= pc[31];
      if (take_illop) begin
        cause <= CAUSE_ILLOP;
        if (pc[31])
          dbl_fault <= 1'b1;
      end else if (take_irq) begin
        cause <= CAUSE_IRQ;
      end
      if ((take_illop || take_irq) && (trap_cnt != '1))
        trap_cnt <= trap_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      case (state)
        ST_RUN: begin
          if (halt_req && !take_illop && !take_irq) begin
            state  <= ST_HALT;
            halted <= 1'b1;
          end
        end
        ST_HALT: begin
          if (!halt_req) begin
            state  <= ST_RUN;
            halted <= 1'b0;
          end
        end
        default: begin
          state  <= ST_RUN;
          halted <= 1'b0;
        end
      endcase
    end
  end

endmodule
